// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the default operand width.
package serial_add_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder: the only arithmetic element of the serial datapath.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | ((x | y) & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one result bit per clock, LSB first,
// through a single full-adder cell; result, carry and overflow held after done.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             fa_s;
  logic             fa_co;
  logic             last;

  assign last = (cnt_reg == LAST);

  // Operands shift right so the current bit is always at position 0.
  fa_cell u_fa (
    .x  (a_reg[0]),
    .y  (b_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub;
            cnt_reg   <= '0;
            sum_reg   <= '0;
          end
        end
        RUN: begin
          a_reg            <= a_reg >> 1;
          b_reg            <= b_reg >> 1;
          sum_reg[cnt_reg] <= fa_s;
          carry_reg        <= fa_co;
          if (last) begin
            // carry_reg still holds the carry into the MSB here.
            cout_reg <= fa_co;
            ovf_reg  <= carry_reg ^ fa_co;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8: directed vector table,
// back-to-back start, mid-run reset, and a short model-checked random run.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_cmp;
  int n_fail;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    int   lat;
    logic excl;
    lat   = 0;
    excl  = 1'b0;
    a     = ta;
    b     = tb_v;
    sub   = ts;
    start = 1'b1;
    for (int k = 1; k <= W + 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        start = 1'b0;
        chk("busy_in_run", {31'd0, busy}, 32'd1);
      end
      if (busy && done) excl = 1'b1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, W + 1);
    chk("sum", {24'd0, sum}, {24'd0, es});
    chk("cout", {31'd0, cout}, {31'd0, ec});
    chk("ovf", {31'd0, ovf}, {31'd0, eo});
    chk("busy_done_excl", {31'd0, excl}, 32'd0);
    $display("op a=%02h b=%02h sub=%0d -> sum=%02h cout=%0d ovf=%0d lat=%0d (exp %02h %0d %0d)",
             ta, tb_v, ts, sum, cout, ovf, lat, es, ec, eo);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("sum_hold", {24'd0, sum}, {24'd0, es});
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] bb;
    logic [W-1:0] es;
    logic         rs;
    logic [W:0]   full;
    logic         eo;
    int           n_done;
    int           done_at[$];
    int           gap_bad;

    n_cmp  = 0;
    n_fail = 0;

    vecs[0]  = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3]  = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[4]  = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1};
    vecs[7]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[8]  = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[9]  = '{8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
    end

    // start held for 30 cycles; operands scrambled whenever busy is seen high.
    n_done  = 0;
    gap_bad = 0;
    a       = 8'h11;
    b       = 8'h22;
    sub     = 1'b0;
    start   = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      chk("b2b_excl", {31'd0, busy & done}, 32'd0);
      if (done) begin
        n_done++;
        done_at.push_back(k);
        chk("b2b_sum", {24'd0, sum}, 32'h33);
      end
      if (done_at.size() > 0) begin
        if (k == done_at[$] + 1 && (busy || done)) gap_bad++;
        if (k == done_at[$] + 2 && !busy) gap_bad++;
      end
      if (busy) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end else begin
        a = 8'h11;
        b = 8'h22;
      end
    end
    start = 1'b0;
    $display("b2b: %0d done pulses, gap errors %0d", n_done, gap_bad);
    chk("b2b_count", n_done, 3);
    chk("b2b_first", (done_at.size() > 0) ? done_at[0] : 0, W + 1);
    chk("b2b_gap", gap_bad, 0);
    @(posedge clk);
    #1;
    chk("b2b_idle_after", {31'd0, busy}, 32'd0);

    // Prime cout/ovf to 1, then abort a run with reset.
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    a     = 8'h35;
    b     = 8'h4A;
    sub   = 1'b0;
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk);
        #1;
        if (done || busy) seen++;
      end
      chk("abort_no_done", seen, 0);
    end
    $display("reset abort checked");
    run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rs   = 1'($urandom_range(0, 1));
      bb   = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bb} + {8'd0, rs};
      es   = full[W-1:0];
      eo   = (ra[W-1] == bb[W-1]) && (es[W-1] != ra[W-1]);
      run_op(ra, rb, rs, es, full[W], eo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
